// File: rtl/compound_accumulator_if.sv
// CompoundType transaction types and the notify/sync bus of the accumulator.
// The master drives the transaction and the result acceptance; the slave drives notifies and the result.
package compound_pkg;
  typedef enum logic {MODE_READ = 1'b0, MODE_WRITE = 1'b1} mode_e;

  typedef struct packed {
    mode_e              mode;
    logic signed [31:0] x;
    logic               y;
  } compound_t;

  typedef enum logic {ST_ACCEPT = 1'b0, ST_EMIT = 1'b1} acc_state_e;
endpackage

// Handshake: a port transfers on a rising edge where its notify (from the
// sender of readiness/validity) and sync are both 1; data is sampled at that edge.
interface compound_accumulator_if;
  compound_pkg::compound_t acc_in;
  logic                    acc_in_sync;
  logic                    acc_in_notify;
  logic signed [31:0]      res_out;
  logic                    res_out_sync;
  logic                    res_out_notify;

  modport master (
    output acc_in, acc_in_sync, res_out_sync,
    input  acc_in_notify, res_out, res_out_notify
  );

  modport slave (
    input  acc_in, acc_in_sync, res_out_sync,
    output acc_in_notify, res_out, res_out_notify
  );
endinterface

// File: rtl/compound_accumulator.sv
// Signed accumulator fed by CompoundType transactions; reads emit a snapshot
// over the result port, optionally clearing the accumulator once it is accepted.
module compound_accumulator
  import compound_pkg::*;
#(
  parameter bit SATURATE = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  compound_accumulator_if.slave bus,
  output logic                 ovf,
  output logic [CNT_W-1:0]     wr_count,
  output acc_state_e           dbg_state
);

  acc_state_e         r_state;
  acc_state_e         w_next_state;
  logic               r_in_notify;
  logic               r_out_notify;
  logic               r_clear_pending;
  logic               r_ovf;
  logic signed [31:0] r_acc;
  logic signed [31:0] r_res;
  logic [CNT_W-1:0]   r_wr_count;

  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_is_write;
  logic [32:0]        w_sum;
  logic               w_overflow;
  logic signed [31:0] w_acc_next;

  assign w_in_xfer  = r_in_notify & bus.acc_in_sync;
  assign w_out_xfer = r_out_notify & bus.res_out_sync;
  assign w_is_write = (bus.acc_in.mode == MODE_WRITE);

  // 33-bit sum: the two top bits disagree exactly when the 32-bit result overflowed.
  assign w_sum      = {r_acc[31], r_acc} + {bus.acc_in.x[31], bus.acc_in.x};
  assign w_overflow = w_sum[32] ^ w_sum[31];

  always_comb begin
    w_acc_next = w_sum[31:0];
    if (SATURATE && w_overflow) begin
      w_acc_next = w_sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_ACCEPT: if (w_in_xfer && !w_is_write) w_next_state = ST_EMIT;
      ST_EMIT:   if (w_out_xfer)               w_next_state = ST_ACCEPT;
      default:   w_next_state = ST_ACCEPT;
    endcase
  end

  // Notifies are registered alongside the state so both follow the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_ACCEPT;
      r_in_notify  <= 1'b1;
      r_out_notify <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_in_notify  <= (w_next_state == ST_ACCEPT);
      r_out_notify <= (w_next_state == ST_EMIT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc           <= '0;
      r_res           <= '0;
      r_ovf           <= 1'b0;
      r_wr_count      <= '0;
      r_clear_pending <= 1'b0;
    end else begin
      if (w_in_xfer) begin
        if (w_is_write) begin
          if (bus.acc_in.y) begin
            r_acc      <= bus.acc_in.x;
            r_ovf      <= 1'b0;
            r_wr_count <= CNT_W'(1);
          end else begin
            r_acc      <= w_acc_next;
            r_ovf      <= r_ovf | w_overflow;
            r_wr_count <= r_wr_count + CNT_W'(1);
          end
        end else begin
          r_res           <= r_acc;
          r_clear_pending <= bus.acc_in.y;
        end
      end
      // Clear is deferred until the snapshot has actually been taken downstream.
      if (w_out_xfer && r_clear_pending) begin
        r_acc           <= '0;
        r_ovf           <= 1'b0;
        r_wr_count      <= '0;
        r_clear_pending <= 1'b0;
      end
    end
  end

  assign bus.acc_in_notify  = r_in_notify;
  assign bus.res_out_notify = r_out_notify;
  assign bus.res_out        = r_res;
  assign ovf                = r_ovf;
  assign wr_count           = r_wr_count;
  assign dbg_state          = r_state;

endmodule
